escreve_matriz_ram: RTL and testbench

- Writer side of the matrix/RAM interface.
- Takes a packed 5x5 result matrix (25 elements x 9 bits = 225 bits) on a start request.
- Streams the elements, one per cycle, into the single-port `fluxo_ram` result region (default base address 50, addresses 50..74).
- Reports busy/done; optionally reads the region back and flags mismatches.

---
 rtl/matriz_pkg.sv | 18 +
 rtl/escreve_matriz_ram_seleciona_elem.sv | 24 ++
 rtl/escreve_matriz_ram.sv | 217 +++++++++++++++++++++
 tb/tb_escreve_matriz_ram.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix/RAM writer and reader blocks.
// Optional verify pass is enabled with ESCREVE_MATRIZ_VERIFY_EN.
package matriz_pkg;

    localparam int ELEM_W    = 9;
    localparam int N_ELEM    = 25;
    localparam int MATRIX_W  = ELEM_W * N_ELEM;
    localparam int ADDR_W    = 8;
    localparam int BASE_ADDR = 50;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } estado_t;

endpackage

// File: rtl/escreve_matriz_ram_seleciona_elem.sv
// Combinational index-to-element selector over a packed matrix vector.
// Out-of-range indices return zero.
module seleciona_elem #(
    parameter int ELEM_W = matriz_pkg::ELEM_W,
    parameter int N_ELEM = matriz_pkg::N_ELEM,
    parameter int IDX_W  = 5
) (
    input  logic [ELEM_W*N_ELEM-1:0] vetor,
    input  logic [IDX_W-1:0]         idx,
    output logic [ELEM_W-1:0]        elem
);
    import matriz_pkg::*;

    // Element mux: one slice per index value
    always_comb begin
        elem = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (idx == IDX_W'(i)) begin
                elem = vetor[i*ELEM_W +: ELEM_W];
            end
        end
    end

endmodule

// File: rtl/escreve_matriz_ram.sv
// Writer side of the matrix/RAM interface: latches a packed matrix on start
// and streams one element per cycle into the RAM result region.
// Define ESCREVE_MATRIZ_VERIFY_EN to add a read-back pass that sets erro.
module escreve_matriz_ram #(
    parameter int ELEM_W    = matriz_pkg::ELEM_W,
    parameter int N_ELEM    = matriz_pkg::N_ELEM,
    parameter int ADDR_W    = matriz_pkg::ADDR_W,
    parameter int BASE_ADDR = matriz_pkg::BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ELEM_W*N_ELEM-1:0] matriz_in,
    output logic [ADDR_W-1:0]        ram_endereco,
    output logic [ELEM_W-1:0]        ram_dado,
    output logic                     ram_grava,
    input  logic [ELEM_W-1:0]        ram_dado_lido,
    output logic                     busy,
    output logic                     done,
    output logic                     erro
);
    import matriz_pkg::*;

    localparam int MAT_W = ELEM_W * N_ELEM;
    // One spare code so the verify pass can count a drain step past the last read
    localparam int IDX_W = $clog2(N_ELEM + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    estado_t            estado_q, estado_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [MAT_W-1:0]   mat_q, mat_d;
    logic [ADDR_W-1:0]  endereco_q, endereco_d;
    logic [ELEM_W-1:0]  dado_q, dado_d;
    logic               grava_q, grava_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ELEM_W-1:0]  elem_atual;

    seleciona_elem #(
        .ELEM_W (ELEM_W),
        .N_ELEM (N_ELEM),
        .IDX_W  (IDX_W)
    ) u_sel_escrita (
        .vetor (mat_q),
        .idx   (idx_q),
        .elem  (elem_atual)
    );

    // State register, element index and latched matrix
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            idx_q    <= '0;
            mat_q    <= '0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            mat_q    <= mat_d;
        end
    end

    // Next-state logic: accept start only in IDLE, walk the index through each pass
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        mat_d    = mat_q;
        case (estado_q)
            IDLE: begin
                if (start) begin
                    mat_d    = matriz_in;
                    idx_d    = '0;
                    estado_d = WRITE;
                end
            end
            WRITE: begin
                if (idx_q == IDX_W'(N_ELEM - 1)) begin
                    idx_d = '0;
`ifdef ESCREVE_MATRIZ_VERIFY_EN
                    estado_d = VERIFY;
`else
                    estado_d = DONE;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`ifdef ESCREVE_MATRIZ_VERIFY_EN
            VERIFY: begin
                // Index N_ELEM is a drain step that lets the last read return
                if (idx_q == IDX_W'(N_ELEM)) begin
                    idx_d    = '0;
                    estado_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`endif
            DONE: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Registered RAM-side outputs; address and data hold when not driven
    always_comb begin
        endereco_d = endereco_q;
        dado_d     = dado_q;
        grava_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (estado_q)
            WRITE: begin
                grava_d    = 1'b1;
                busy_d     = 1'b1;
                endereco_d = BASE + ADDR_W'(idx_q);
                dado_d     = elem_atual;
            end
`ifdef ESCREVE_MATRIZ_VERIFY_EN
            VERIFY: begin
                busy_d = 1'b1;
                if (idx_q < IDX_W'(N_ELEM)) begin
                    endereco_d = BASE + ADDR_W'(idx_q);
                end
            end
`endif
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Output register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            endereco_q <= '0;
            dado_q     <= '0;
            grava_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            endereco_q <= endereco_d;
            dado_q     <= dado_d;
            grava_q    <= grava_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ram_endereco = endereco_q;
    assign ram_dado     = dado_q;
    assign ram_grava    = grava_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef ESCREVE_MATRIZ_VERIFY_EN
    logic               rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic               cmp_vld_q, cmp_vld_d;
    logic [IDX_W-1:0]   cmp_idx_q, cmp_idx_d;
    logic               erro_q, erro_d;
    logic [ELEM_W-1:0]  elem_cmp;

    seleciona_elem #(
        .ELEM_W (ELEM_W),
        .N_ELEM (N_ELEM),
        .IDX_W  (IDX_W)
    ) u_sel_verif (
        .vetor (mat_q),
        .idx   (cmp_idx_q),
        .elem  (elem_cmp)
    );

    // Read tracking: rd_* marks the cycle the address is on the bus,
    // cmp_* marks the following cycle when the RAM data is valid
    always_comb begin
        rd_vld_d  = (estado_q == VERIFY) && (idx_q < IDX_W'(N_ELEM));
        rd_idx_d  = idx_q;
        cmp_vld_d = rd_vld_q;
        cmp_idx_d = rd_idx_q;
        erro_d    = erro_q;
        if (estado_q == IDLE && start) begin
            erro_d = 1'b0;
        end else if (cmp_vld_q && (ram_dado_lido != elem_cmp)) begin
            erro_d = 1'b1;
        end
    end

    // Verify pipeline and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            cmp_vld_q <= 1'b0;
            cmp_idx_q <= '0;
            erro_q    <= 1'b0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_idx_q  <= rd_idx_d;
            cmp_vld_q <= cmp_vld_d;
            cmp_idx_q <= cmp_idx_d;
            erro_q    <= erro_d;
        end
    end

    assign erro = erro_q;
`else
    logic unused_lido;
    assign unused_lido = ^ram_dado_lido;
    assign erro        = 1'b0;
`endif

endmodule

// File: tb/tb_escreve_matriz_ram.sv
// Directed bench for escreve_matriz_ram: default-base instance plus a
// BASE_ADDR=240 instance to exercise address wrap, each with a RAM model.
module tb_escreve_matriz_ram;

    localparam int EW = 9;
    localparam int NE = 25;
`ifdef ESCREVE_MATRIZ_VERIFY_EN
    localparam int LAT = 52;
`else
    localparam int LAT = 26;
`endif

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [224:0]   matriz_in;
    logic [7:0]     end_a, end_b;
    logic [8:0]     dado_a, dado_b, lido_a, lido_b;
    logic           grava_a, grava_b, busy_a, busy_b, done_a, done_b, erro_a, erro_b;
    logic           corrupt;
    logic [8:0]     mem_a [256];
    logic [8:0]     mem_b [256];
    int             total;
    int             bad;

    escreve_matriz_ram dut (
        .clk(clk), .rst_n(rst_n), .start(start), .matriz_in(matriz_in),
        .ram_endereco(end_a), .ram_dado(dado_a), .ram_grava(grava_a),
        .ram_dado_lido(lido_a), .busy(busy_a), .done(done_a), .erro(erro_a)
    );

    escreve_matriz_ram #(.BASE_ADDR(240)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .matriz_in(matriz_in),
        .ram_endereco(end_b), .ram_dado(dado_b), .ram_grava(grava_b),
        .ram_dado_lido(lido_b), .busy(busy_b), .done(done_b), .erro(erro_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM models with 1-cycle read latency; A can corrupt address 60
    always @(posedge clk) begin
        if (grava_a) mem_a[end_a] <= dado_a;
        if (grava_b) mem_b[end_b] <= dado_b;
        lido_a <= mem_a[end_a] ^ ((corrupt && end_a == 8'd60) ? 9'd1 : 9'd0);
        lido_b <= mem_b[end_b];
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] ev(input int mode, input int i);
        case (mode)
            0:       return 9'(i + 1);
            1:       return 9'((i * 37 + 5) % 512);
            default: return 9'(511 - i * 3);
        endcase
    endfunction

    function automatic logic [224:0] mk(input int mode);
        logic [224:0] m;
        m = '0;
        for (int i = 0; i < NE; i++) m[i*EW +: EW] = ev(mode, i);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; matriz_in = '0; corrupt = 1'b0;
        lido_a = '0; lido_b = '0;
        for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        #1 rst_n = 1'b0;
        #2;
        total++; if (end_a !== 8'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", end_a); end
        total++; if (dado_a !== 9'd0) begin bad++; $display("FAIL rst_dado got=%0d want=0", dado_a); end
        total++; if (grava_a !== 1'b0) begin bad++; $display("FAIL rst_grava got=%b want=0", grava_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_a); end
        total++; if (erro_a !== 1'b0) begin bad++; $display("FAIL rst_erro got=%b want=0", erro_a); end
        tick(); tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        matriz_in = mk(0); start = 1'b1;
        tick();                               // edge T0
        start = 1'b0; matriz_in = '0;
        total++; if (busy_a !== 1'b0 || grava_a !== 1'b0) begin
            bad++; $display("FAIL t0_idle busy=%b grava=%b want 0 0", busy_a, grava_a); end
        for (int k = 1; k <= NE; k++) begin
            tick();
            total++;
            if ({grava_a, busy_a, done_a, erro_a} !== 4'b1100 || end_a !== 8'(49 + k) || dado_a !== ev(0, k - 1)) begin
                bad++; $display("FAIL write T%0d g/b/d/e=%b%b%b%b addr=%0d dado=%0d want 1100 addr=%0d dado=%0d",
                                k, grava_a, busy_a, done_a, erro_a, end_a, dado_a, 49 + k, ev(0, k - 1));
            end
            total++;
            if (grava_b !== 1'b1 || end_b !== 8'(239 + k) || dado_b !== ev(0, k - 1)) begin
                bad++; $display("FAIL wrap T%0d grava=%b addr=%0d dado=%0d want 1 addr=%0d dado=%0d",
                                k, grava_b, end_b, dado_b, (239 + k) % 256, ev(0, k - 1));
            end
        end
`ifdef ESCREVE_MATRIZ_VERIFY_EN
        for (int j = 0; j <= NE; j++) begin
            tick();
            total++;
            if ({grava_a, busy_a, done_a, erro_a} !== 4'b0100 || end_a !== 8'(50 + ((j < NE) ? j : NE - 1))) begin
                bad++; $display("FAIL verify_rd T%0d g/b/d/e=%b%b%b%b addr=%0d want 0100 addr=%0d",
                                26 + j, grava_a, busy_a, done_a, erro_a, end_a, 50 + ((j < NE) ? j : NE - 1));
            end
        end
`endif
        tick();                               // T26 or T52
        total++; if ({done_a, busy_a, grava_a, erro_a} !== 4'b1000) begin
            bad++; $display("FAIL done_cycle d/b/g/e=%b%b%b%b want 1000", done_a, busy_a, grava_a, erro_a); end
        total++; if (done_b !== 1'b1 || erro_b !== 1'b0) begin
            bad++; $display("FAIL done_wrap done=%b erro=%b want 1 0", done_b, erro_b); end
        tick();
        total++; if (done_a !== 1'b0 || grava_a !== 1'b0) begin
            bad++; $display("FAIL done_pulse done=%b grava=%b want 0 0", done_a, grava_a); end
        total++; if (end_a !== 8'd74 || dado_a !== 9'd25) begin
            bad++; $display("FAIL idle_hold addr=%0d dado=%0d want 74 25", end_a, dado_a); end
        for (int i = 0; i < NE; i++) begin
            total++; if (mem_a[50 + i] !== ev(0, i)) begin
                bad++; $display("FAIL mem_a[%0d] got=%0d want=%0d", 50 + i, mem_a[50 + i], ev(0, i)); end
            total++; if (mem_b[(240 + i) % 256] !== ev(0, i)) begin
                bad++; $display("FAIL mem_b[%0d] got=%0d want=%0d", (240 + i) % 256, mem_b[(240 + i) % 256], ev(0, i)); end
        end
    endtask

    task automatic test_ignore_start();
        int n;
        matriz_in = mk(1); start = 1'b1;
        tick();                               // T0
        start = 1'b0; matriz_in = mk(2);
        repeat (9) tick();                    // period T9
        start = 1'b1;
        tick();                               // edge T10 sees start
        start = 1'b0;
        n = 10;
        while (done_a !== 1'b1 && n < 120) begin tick(); n++; end
        total++; if (n !== LAT) begin
            bad++; $display("FAIL ignore_latency got=%0d want=%0d", n, LAT); end
        repeat (3) begin
            tick();
            total++; if (grava_a !== 1'b0 || busy_a !== 1'b0) begin
                bad++; $display("FAIL ignore_requeue grava=%b busy=%b want 0 0", grava_a, busy_a); end
        end
        for (int i = 0; i < NE; i++) begin
            total++; if (mem_a[50 + i] !== ev(1, i)) begin
                bad++; $display("FAIL ignore_mem[%0d] got=%0d want=%0d", 50 + i, mem_a[50 + i], ev(1, i)); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        matriz_in = mk(2); start = 1'b1;
        tick();                               // T0, start stays high
        n = 0;
        while (done_a !== 1'b1 && n < 120) begin tick(); n++; end
        total++; if (n !== LAT) begin
            bad++; $display("FAIL b2b_latency got=%0d want=%0d", n, LAT); end
        tick();                               // idle cycle, relaunch accepted at its end
        total++; if ({grava_a, busy_a, done_a} !== 3'b000) begin
            bad++; $display("FAIL b2b_gap g/b/d=%b%b%b want 000", grava_a, busy_a, done_a); end
        tick();
        start = 1'b0;
        total++; if (grava_a !== 1'b1 || busy_a !== 1'b1 || end_a !== 8'd50 || dado_a !== ev(2, 0)) begin
            bad++; $display("FAIL b2b_restart grava=%b busy=%b addr=%0d dado=%0d want 1 1 50 %0d",
                            grava_a, busy_a, end_a, dado_a, ev(2, 0)); end
        n = 1;
        while (done_a !== 1'b1 && n < 120) begin tick(); n++; end
        total++; if (n !== LAT) begin
            bad++; $display("FAIL b2b_latency2 got=%0d want=%0d", n, LAT); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        matriz_in = mk(0); start = 1'b1;
        tick();                               // T0
        start = 1'b0;
        repeat (12) tick();                   // period T12
        total++; if (grava_a !== 1'b1 || end_a !== 8'd61) begin
            bad++; $display("FAIL mid_pre grava=%b addr=%0d want 1 61", grava_a, end_a); end
        #2 rst_n = 1'b0;
        #1;                                   // still before the next edge
        total++; if ({grava_a, busy_a, done_a} !== 3'b000 || end_a !== 8'd0 || dado_a !== 9'd0) begin
            bad++; $display("FAIL mid_async g/b/d=%b%b%b addr=%0d dado=%0d want 000 0 0",
                            grava_a, busy_a, done_a, end_a, dado_a); end
        @(negedge clk) rst_n = 1'b1;
        matriz_in = mk(1); start = 1'b1;
        tick();                               // T0
        start = 1'b0;
        tick();                               // T1
        total++; if (grava_a !== 1'b1 || end_a !== 8'd50 || dado_a !== ev(1, 0)) begin
            bad++; $display("FAIL mid_restart grava=%b addr=%0d dado=%0d want 1 50 %0d",
                            grava_a, end_a, dado_a, ev(1, 0)); end
        n = 1;
        while (done_a !== 1'b1 && n < 120) begin tick(); n++; end
        total++; if (n !== LAT) begin
            bad++; $display("FAIL mid_latency got=%0d want=%0d", n, LAT); end
        tick();
    endtask

`ifdef ESCREVE_MATRIZ_VERIFY_EN
    task automatic test_verify_error();
        int n;
        corrupt = 1'b1;
        matriz_in = mk(0); start = 1'b1;
        tick();                               // T0
        start = 1'b0;
        for (int p = 1; p <= 52; p++) begin
            tick();
            total++; if (erro_a !== ((p >= 38) ? 1'b1 : 1'b0) || done_a !== ((p == 52) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL verr T%0d erro=%b done=%b want %b %b",
                                p, erro_a, done_a, (p >= 38), (p == 52)); end
        end
        repeat (3) tick();
        total++; if (erro_a !== 1'b1 || erro_b !== 1'b0) begin
            bad++; $display("FAIL verr_sticky erro_a=%b erro_b=%b want 1 0", erro_a, erro_b); end
        corrupt = 1'b0;
        start = 1'b1;
        tick();                               // T0 clears erro
        start = 1'b0;
        total++; if (erro_a !== 1'b0) begin
            bad++; $display("FAIL verr_clear erro=%b want 0", erro_a); end
        n = 0;
        while (done_a !== 1'b1 && n < 120) begin tick(); n++; end
        total++; if (n !== 52 || erro_a !== 1'b0) begin
            bad++; $display("FAIL verr_clean latency=%0d erro=%b want 52 0", n, erro_a); end
        tick();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef ESCREVE_MATRIZ_VERIFY_EN
        test_verify_error();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
